regfile_bus_master: RTL and testbench



---
 rtl/regfile_bus_pkg.sv | 20 ++
 rtl/regfile_bus_master_if.sv | 36 +++
 rtl/regfile_bus_master.sv | 125 ++++++++++++
 tb/tb_regfile_bus_master.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_bus_pkg.sv
// Shared types and constants for the register-file bus master.
package regfile_bus_pkg;

    localparam int ADDR_W        = 8;
    localparam int DEFAULT_DEPTH = 64;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_ADDR,
        RD_CAP,
        RESP
    } state_t;

    // True when the address selects an implemented register entry.
    function automatic logic addr_legal(input logic [ADDR_W-1:0] addr, input int depth);
        return int'(addr) < depth;
    endfunction

endpackage

// File: rtl/regfile_bus_master_if.sv
// Command/response handshake plus the registered address/write-enable bus lines.
// The bidirectional data line stays a plain module port so that the tri-state
// resolution happens on a net outside the interface.
interface regfile_bus_master_if #(
    parameter int DATA_W = 8
);
    import regfile_bus_pkg::*;

    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_write;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [DATA_W-1:0]   cmd_wdata;

    logic                rsp_valid;
    logic                rsp_ready;
    logic                rsp_write;
    logic                rsp_err;
    logic [DATA_W-1:0]   rsp_rdata;

    logic [ADDR_W-1:0]   bus_address;
    logic                bus_en_write;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_write, rsp_err, rsp_rdata,
        output bus_address, bus_en_write
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_write, rsp_err, rsp_rdata,
        input  bus_address, bus_en_write
    );

endinterface

// File: rtl/regfile_bus_master.sv
// Initiator for the shared-bus register files: sequences one bus cycle per
// command, owns the data-bus direction and returns a response per command.
module regfile_bus_master
    import regfile_bus_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = DEFAULT_DEPTH
) (
    input  logic                 clock,
    input  logic                 reset,
    regfile_bus_master_if.master bif,
    inout  wire  [DATA_W-1:0]    bus_data
);

    state_t              state_reg,     state_next;
    logic [ADDR_W-1:0]   addr_reg,      addr_next;
    logic                en_write_reg,  en_write_next;
    logic [DATA_W-1:0]   wdata_reg,     wdata_next;
    logic                rsp_write_reg, rsp_write_next;
    logic                rsp_err_reg,   rsp_err_next;
    logic [DATA_W-1:0]   rdata_reg,     rdata_next;

    logic                cmd_ready;
    logic                accept;
    logic                drive_en;

    // A new command can be taken while idle, or in the same cycle the
    // pending response retires.
    assign cmd_ready = !reset && (state_reg == IDLE || (state_reg == RESP && bif.rsp_ready));
    assign accept    = bif.cmd_valid && cmd_ready;

    // The drive enable is the registered write strobe itself, so the register
    // file (which drives whenever en_write is low) never overlaps with us.
    assign drive_en  = en_write_reg;
    assign bus_data  = drive_en ? wdata_reg : {DATA_W{1'bz}};

    assign bif.cmd_ready    = cmd_ready;
    assign bif.rsp_valid    = (state_reg == RESP);
    assign bif.rsp_write    = rsp_write_reg;
    assign bif.rsp_err      = rsp_err_reg;
    assign bif.rsp_rdata    = rdata_reg;
    assign bif.bus_address  = addr_reg;
    assign bif.bus_en_write = en_write_reg;

    // Next-state and next-register computation; an accepted command overrides
    // whatever the current state decided.
    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        en_write_next  = 1'b0;
        wdata_next     = wdata_reg;
        rsp_write_next = rsp_write_reg;
        rsp_err_next   = rsp_err_reg;
        rdata_next     = rdata_reg;

        case (state_reg)
            IDLE: begin
                state_next = IDLE;
            end
            WRITE: begin
                state_next     = RESP;
                rsp_write_next = 1'b1;
                rsp_err_next   = 1'b0;
                rdata_next     = '0;
            end
            RD_ADDR: begin
                state_next = RD_CAP;
            end
            RD_CAP: begin
                state_next     = RESP;
                rsp_write_next = 1'b0;
                rsp_err_next   = 1'b0;
                rdata_next     = bus_data;
            end
            RESP: begin
                if (bif.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (accept) begin
            if (!addr_legal(bif.cmd_addr, DEPTH)) begin
                // Illegal address: answer directly, leave the bus untouched.
                state_next     = RESP;
                rsp_write_next = bif.cmd_write;
                rsp_err_next   = 1'b1;
                rdata_next     = '0;
            end else if (bif.cmd_write) begin
                state_next    = WRITE;
                addr_next     = bif.cmd_addr;
                en_write_next = 1'b1;
                wdata_next    = bif.cmd_wdata;
            end else begin
                state_next = RD_ADDR;
                addr_next  = bif.cmd_addr;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            en_write_reg  <= 1'b0;
            wdata_reg     <= '0;
            rsp_write_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rdata_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            en_write_reg  <= en_write_next;
            wdata_reg     <= wdata_next;
            rsp_write_reg <= rsp_write_next;
            rsp_err_reg   <= rsp_err_next;
            rdata_reg     <= rdata_next;
        end
    end

endmodule

// File: tb/tb_regfile_bus_master.sv
// Bench for regfile_bus_master: an 8-bit and a 1-bit instance, each attached
// to a behavioural register file, checked every cycle against a transaction
// level model plus directed scenarios with literal expectations.
module tb_regfile_bus_master;

    logic clock = 1'b0;
    logic reset;
    logic rf_clr;

    always #5 clock = ~clock;

    regfile_bus_master_if #(.DATA_W(8)) if8 ();
    regfile_bus_master_if #(.DATA_W(1)) if1 ();

    wire [7:0] bus8;
    wire [0:0] bus1;

    logic [1:0] c_valid;
    logic [1:0] c_write;
    logic [1:0] r_ready;
    logic [7:0] c_addr  [2];
    logic [7:0] c_wdata [2];

    assign if8.cmd_valid = c_valid[0];
    assign if8.cmd_write = c_write[0];
    assign if8.cmd_addr  = c_addr[0];
    assign if8.cmd_wdata = c_wdata[0];
    assign if8.rsp_ready = r_ready[0];
    assign if1.cmd_valid = c_valid[1];
    assign if1.cmd_write = c_write[1];
    assign if1.cmd_addr  = c_addr[1];
    assign if1.cmd_wdata = c_wdata[1][0:0];
    assign if1.rsp_ready = r_ready[1];

    regfile_bus_master #(.DATA_W(8), .DEPTH(64)) dut8 (
        .clock    (clock),
        .reset    (reset),
        .bif      (if8.master),
        .bus_data (bus8)
    );

    regfile_bus_master #(.DATA_W(1), .DEPTH(64)) dut1 (
        .clock    (clock),
        .reset    (reset),
        .bif      (if1.master),
        .bus_data (bus1)
    );

    // Register file models: write on en_write, output register reloaded every
    // edge, bus driven whenever en_write is low.
    logic [7:0] rf8_mem [256];
    logic [7:0] rf8_out;
    logic       rf1_mem [256];
    logic       rf1_out;

    always @(posedge clock) begin
        if (rf_clr) begin
            for (int k = 0; k < 256; k++) rf8_mem[k] <= '0;
            rf8_out <= '0;
        end else begin
            if (if8.bus_en_write) rf8_mem[if8.bus_address] <= bus8;
            rf8_out <= rf8_mem[if8.bus_address];
        end
    end

    always @(posedge clock) begin
        if (rf_clr) begin
            for (int k = 0; k < 256; k++) rf1_mem[k] <= 1'b0;
            rf1_out <= 1'b0;
        end else begin
            if (if1.bus_en_write) rf1_mem[if1.bus_address] <= bus1[0];
            rf1_out <= rf1_mem[if1.bus_address];
        end
    end

    assign bus8 = if8.bus_en_write ? 8'bz : rf8_out;
    assign bus1 = if1.bus_en_write ? 1'bz : rf1_out;

    // Observed DUT outputs, widened to a common shape.
    logic [1:0] o_ready, o_valid, o_rw, o_err, o_we;
    logic [7:0] o_rdata [2];
    logic [7:0] o_addr  [2];
    logic [7:0] o_bus   [2];

    assign o_ready = {if1.cmd_ready,    if8.cmd_ready};
    assign o_valid = {if1.rsp_valid,    if8.rsp_valid};
    assign o_rw    = {if1.rsp_write,    if8.rsp_write};
    assign o_err   = {if1.rsp_err,      if8.rsp_err};
    assign o_we    = {if1.bus_en_write, if8.bus_en_write};
    assign o_rdata[0] = if8.rsp_rdata;
    assign o_rdata[1] = {7'b0, if1.rsp_rdata};
    assign o_addr[0]  = if8.bus_address;
    assign o_addr[1]  = if1.bus_address;
    assign o_bus[0]   = bus8;
    assign o_bus[1]   = {7'b0, bus1};

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Transaction-level model: a pending response with the cycle it becomes
    // visible, the golden memory, and the cycle the write strobe must show.
    bit         pend    [2];
    int         due     [2];
    int         we_cyc  [2];
    logic [7:0] exp_addr[2];
    logic [7:0] exp_wd  [2];
    bit         exp_rw  [2];
    bit         exp_err [2];
    logic [7:0] exp_rd  [2];
    logic [7:0] gmem    [2][64];
    logic [1:0] acc;

    // Per-cycle comparison against the model, sampled on the falling edge.
    initial begin
        int   cyc;
        bit   ev, er, ewe;
        logic [7:0] msk;
        cyc = 0;
        acc = '0;
        for (int i = 0; i < 2; i++) begin
            pend[i] = 0; due[i] = 0; we_cyc[i] = -1; exp_addr[i] = '0; exp_wd[i] = '0;
            exp_rw[i] = 0; exp_err[i] = 0; exp_rd[i] = '0;
            for (int a = 0; a < 64; a++) gmem[i][a] = '0;
        end
        forever begin
            @(negedge clock);
            for (int i = 0; i < 2; i++) begin
                msk = (i == 0) ? 8'hFF : 8'h01;
                ev  = pend[i] && (cyc >= due[i]);
                er  = !reset && (!pend[i] || (ev && r_ready[i]));
                ewe = (cyc == we_cyc[i]);
                chk($sformatf("cmd_ready[%0d]@%0d", i, cyc), 32'(o_ready[i]), 32'(er));
                chk($sformatf("rsp_valid[%0d]@%0d", i, cyc), 32'(o_valid[i]), 32'(ev));
                chk($sformatf("bus_en_write[%0d]@%0d", i, cyc), 32'(o_we[i]), 32'(ewe));
                chk($sformatf("bus_address[%0d]@%0d", i, cyc), 32'(o_addr[i]), 32'(exp_addr[i]));
                if (ev) begin
                    chk($sformatf("rsp_write[%0d]@%0d", i, cyc), 32'(o_rw[i]), 32'(exp_rw[i]));
                    chk($sformatf("rsp_err[%0d]@%0d", i, cyc), 32'(o_err[i]), 32'(exp_err[i]));
                    chk($sformatf("rsp_rdata[%0d]@%0d", i, cyc), 32'(o_rdata[i]), 32'(exp_rd[i]));
                end
                if (ewe) chk($sformatf("bus_data[%0d]@%0d", i, cyc), 32'(o_bus[i]), 32'(exp_wd[i]));

                acc[i] = er && c_valid[i];
                if (reset) begin
                    pend[i] = 0; exp_addr[i] = '0; we_cyc[i] = -1;
                end else begin
                    if (ev && r_ready[i]) pend[i] = 0;
                    if (acc[i]) begin
                        pend[i] = 1;
                        if (c_addr[i] >= 8'd64) begin
                            due[i] = cyc + 1; exp_rw[i] = c_write[i]; exp_err[i] = 1; exp_rd[i] = '0;
                        end else if (c_write[i]) begin
                            gmem[i][c_addr[i][5:0]] = c_wdata[i] & msk;
                            due[i] = cyc + 2; exp_rw[i] = 1; exp_err[i] = 0; exp_rd[i] = '0;
                            we_cyc[i] = cyc + 1; exp_wd[i] = c_wdata[i] & msk; exp_addr[i] = c_addr[i];
                        end else begin
                            due[i] = cyc + 3; exp_rw[i] = 0; exp_err[i] = 0;
                            exp_rd[i] = gmem[i][c_addr[i][5:0]]; exp_addr[i] = c_addr[i];
                        end
                    end
                end
            end
            cyc++;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Hold the present command until the falling edge shows cmd_ready, then
    // step past the accepting edge.
    task automatic wait_accept(input int i);
        int n;
        n = 0;
        @(negedge clock);
        while (!o_ready[i] && n < 50) begin
            step();
            @(negedge clock);
            n++;
        end
        if (n >= 50) chk("accept_timeout", 32'd0, 32'd1);
        step();
    endtask

    // Count edges after the accept edge until rsp_valid is visible.
    task automatic wait_rsp(input int i, output logic [7:0] rd, output int lat, output bit er);
        lat = 0;
        @(negedge clock);
        while (!o_valid[i] && lat < 50) begin
            lat++;
            @(negedge clock);
        end
        if (lat >= 50) chk("response_timeout", 32'd0, 32'd1);
        rd = o_rdata[i];
        er = o_err[i];
    endtask

    task automatic do_cmd(input int i, input bit w, input logic [7:0] a, input logic [7:0] d,
                          output logic [7:0] rd, output int lat, output bit er);
        c_valid[i] = 1'b1; c_write[i] = w; c_addr[i] = a; c_wdata[i] = d;
        wait_accept(i);
        c_valid[i] = 1'b0;
        wait_rsp(i, rd, lat, er);
    endtask

    initial begin
        logic [7:0] rd, held;
        int         lat;
        bit         er;

        reset = 1'b1; rf_clr = 1'b1;
        c_valid = '0; c_write = '0; r_ready = 2'b11;
        for (int i = 0; i < 2; i++) begin c_addr[i] = '0; c_wdata[i] = '0; end
        repeat (3) step();
        reset = 1'b0; rf_clr = 1'b0;

        // Write then read back address 5.
        do_cmd(0, 1'b1, 8'd5, 8'hA7, rd, lat, er);
        chk("w5_latency", 32'(lat), 32'd1);
        chk("w5_rsp_write", 32'(o_rw[0]), 32'd1);
        step();
        do_cmd(0, 1'b0, 8'd5, 8'h00, rd, lat, er);
        chk("r5_latency", 32'(lat), 32'd2);
        chk("r5_rdata", 32'(rd), 32'hA7);
        step();

        // Read-after-write back to back, second command waiting all along.
        c_valid[0] = 1'b1; c_write[0] = 1'b1; c_addr[0] = 8'd3; c_wdata[0] = 8'h3C;
        wait_accept(0);
        c_write[0] = 1'b0; c_wdata[0] = 8'h00;
        @(negedge clock);
        chk("raw_ready_in_write", 32'(o_ready[0]), 32'd0);
        step();
        @(negedge clock);
        chk("raw_rsp_at_accept", 32'(o_valid[0]), 32'd1);
        chk("raw_ready_at_retire", 32'(o_ready[0]), 32'd1);
        step();
        c_valid[0] = 1'b0;
        wait_rsp(0, rd, lat, er);
        chk("raw_latency", 32'(lat), 32'd2);
        chk("raw_rdata", 32'(rd), 32'h3C);
        step();

        // Out-of-range address: response is registered on the accept edge.
        do_cmd(0, 1'b0, 8'h40, 8'h00, rd, lat, er);
        chk("err_latency", 32'(lat), 32'd0);
        chk("err_flag", 32'(er), 32'd1);
        chk("err_rdata", 32'(rd), 32'd0);
        chk("err_bus_address", 32'(o_addr[0]), 32'd3);
        step();

        // Back-pressure on a read response of address 0x11.
        do_cmd(0, 1'b1, 8'h11, 8'h96, rd, lat, er);
        step();
        r_ready[0] = 1'b0;
        do_cmd(0, 1'b0, 8'h11, 8'h00, held, lat, er);
        step();
        c_valid[0] = 1'b1; c_write[0] = 1'b1; c_addr[0] = 8'd2; c_wdata[0] = 8'h22;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk($sformatf("hold_valid_%0d", k), 32'(o_valid[0]), 32'd1);
            chk($sformatf("hold_rdata_%0d", k), 32'(o_rdata[0]), 32'h96);
            chk($sformatf("hold_ready_%0d", k), 32'(o_ready[0]), 32'd0);
            step();
        end
        r_ready[0] = 1'b1;
        @(negedge clock);
        chk("hold_accept_on_retire", 32'(o_ready[0]), 32'd1);
        step();
        c_valid[0] = 1'b0;
        wait_rsp(0, rd, lat, er);
        chk("hold_next_write_latency", 32'(lat), 32'd1);
        step();

        // Reset while the read sits in its capture cycle.
        c_valid[0] = 1'b1; c_write[0] = 1'b0; c_addr[0] = 8'd5;
        wait_accept(0);
        c_valid[0] = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("rst_rsp_valid", 32'(o_valid[0]), 32'd0);
        chk("rst_en_write", 32'(o_we[0]), 32'd0);
        chk("rst_idle_ready", 32'(o_ready[0]), 32'd1);
        step();
        do_cmd(0, 1'b0, 8'd5, 8'h00, rd, lat, er);
        chk("rst_reread_rdata", 32'(rd), 32'hA7);
        step();

        // One-bit register file.
        do_cmd(1, 1'b1, 8'd63, 8'h01, rd, lat, er); step();
        do_cmd(1, 1'b1, 8'd62, 8'h00, rd, lat, er); step();
        do_cmd(1, 1'b0, 8'd63, 8'h00, rd, lat, er);
        chk("w1_rd63", 32'(rd), 32'd1);
        step();
        do_cmd(1, 1'b0, 8'd62, 8'h00, rd, lat, er);
        chk("w1_rd62", 32'(rd), 32'd0);
        step();

        // Randomized traffic on both instances with back-pressure and resets.
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 149) == 0);
            for (int i = 0; i < 2; i++) begin
                if (!c_valid[i] || acc[i]) begin
                    c_valid[i] = ($urandom_range(0, 2) != 0);
                    c_write[i] = $urandom_range(0, 1);
                    c_addr[i]  = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255))
                                                             : 8'($urandom_range(0, 63));
                    c_wdata[i] = 8'($urandom_range(0, 255));
                end
                r_ready[i] = ($urandom_range(0, 3) != 0);
            end
            step();
        end
        reset = 1'b0; c_valid = '0; r_ready = 2'b11;
        repeat (10) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
